// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRA/SRL shifter applying one power-of-two stage (16,8,4,2,1) per clock
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d, amt;
    logic [2:0]         idx_q, idx_d;
    logic [WIDTH-1:0]   work_q, work_d, sra, stage;
    logic               busy_q, busy_d, done_q, done_d, accept;
    always_comb begin
        amt     = SHAMT_W'(1) << idx_q;
        // kept separate so the arithmetic shift stays in a signed context
        sra     = $signed(work_q) >>> amt;
        stage   = op_q == 2'b00 ? work_q << amt :
                  op_q == 2'b01 ? sra :
                  op_q == 2'b10 ? work_q >> amt : work_q;
        accept  = start && state_q != SHIFT;
        state_d = state_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        idx_d   = idx_q;
        work_d  = work_q;
        if (accept) begin
            state_d = SHIFT;
            op_d    = op;
            shamt_d = shamt;
            idx_d   = 3'd4;
            work_d  = data_in;
        end else if (state_q == SHIFT) begin
            work_d  = shamt_q[idx_q] ? stage : work_q;
            idx_d   = idx_q - 3'd1;
            state_d = idx_q == 3'd0 ? DONE : SHIFT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        busy_d = state_d == SHIFT;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            shamt_q <= '0;
            idx_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = work_q;
endmodule
